// File: rtl/dds_pkg.sv
// dds_pkg: shared widths, gain constant and FTW handshake state for the
// DDS wavetable reader.
package dds_pkg;

    localparam int DDS_PHASE_W          = 32;
    localparam int DDS_SAMPLE_ADDR_BITS = 8;
    localparam int DDS_DATA_W           = 16;
    localparam int DDS_AMP_W            = 9;

    // Amplitude value that means gain 1.0; anything larger is clamped to it.
    localparam int AMP_UNITY = 1 << (DDS_AMP_W - 1);

    // IDLE: ready for a new tuning word.
    // PENDING: holding a word until the accumulator wraps.
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } ftw_state_e;

endpackage

// File: rtl/dds_table_reader_if.sv
// dds_table_reader_if: tuning-word handshake, wavetable ROM port and
// sample output stream of the DDS table reader.
//   master : the reader (drives ftw_ready, bram_ce/addr, sample_out/valid)
//   slave  : the surroundings (tuning-word source, ROM, DAC/PWM sink)
interface dds_table_reader_if
    import dds_pkg::*;
#(
    parameter int PHASE_W          = DDS_PHASE_W,
    parameter int SAMPLE_ADDR_BITS = DDS_SAMPLE_ADDR_BITS,
    parameter int DATA_W           = DDS_DATA_W
);
    logic [PHASE_W-1:0]          ftw_in;
    logic                        ftw_valid;
    logic                        ftw_ready;
    logic                        bram_ce;
    logic [SAMPLE_ADDR_BITS-1:0] bram_addr;
    logic [DATA_W-1:0]           bram_data;
    logic [DATA_W-1:0]           sample_out;
    logic                        sample_valid;

    modport master (
        input  ftw_in, ftw_valid, bram_data,
        output ftw_ready, bram_ce, bram_addr, sample_out, sample_valid
    );

    modport slave (
        output ftw_in, ftw_valid, bram_data,
        input  ftw_ready, bram_ce, bram_addr, sample_out, sample_valid
    );
endinterface

// File: rtl/dds_amp_scale.sv
// dds_amp_scale: clamps the gain to unity, multiplies the signed sample by
// it and renormalises, with one register stage; valid travels alongside.
//   clk_i, rst_i : clock, synchronous active-high reset
//   raw_i        : signed table sample
//   amp_i        : unsigned gain, unity = 2^(AMP_W-1)
//   vld_i        : raw_i is a real sample
//   sample_o     : scaled signed sample (registered)
//   vld_o        : sample_o valid (registered)
module dds_amp_scale #(
    parameter int DATA_W = 16,
    parameter int AMP_W  = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] raw_i,
    input  logic [AMP_W-1:0]  amp_i,
    input  logic              vld_i,
    output logic [DATA_W-1:0] sample_o,
    output logic              vld_o
);
    localparam int PROD_W = DATA_W + AMP_W + 1;
    localparam logic [AMP_W-1:0] UNITY = AMP_W'(1) << (AMP_W - 1);

    logic [AMP_W-1:0]         amp_c;
    logic signed [PROD_W-1:0] raw_x;
    logic signed [PROD_W-1:0] amp_x;
    logic signed [PROD_W-1:0] prod;
    logic [DATA_W-1:0]        sample_q;
    logic                     vld_q;

    // With gain capped at unity the renormalised product always fits DATA_W.
    assign amp_c = (amp_i > UNITY) ? UNITY : amp_i;
    assign raw_x = {{(AMP_W + 1){raw_i[DATA_W-1]}}, raw_i};
    assign amp_x = {{DATA_W{1'b0}}, 1'b0, amp_c};
    assign prod  = raw_x * amp_x;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            sample_q <= DATA_W'(prod >>> (AMP_W - 1));
            vld_q    <= vld_i;
        end
    end

    assign sample_o = sample_q;
    assign vld_o    = vld_q;
endmodule

// File: rtl/dds_table_reader.sv
// dds_table_reader: DDS phase accumulator and wavetable read initiator.
// Issues one ROM read per enabled cycle at the top bits of the phase,
// captures the negedge-registered ROM data, scales it by amp_in and emits
// a valid-tagged sample stream. New tuning words are taken over a
// valid/ready handshake and applied at the next accumulator wrap.
//   dds_clk, dds_rst : clock, synchronous active-high reset
//   dds_en           : advance phase and issue a read this cycle
//   phase_clr        : clear the accumulator (overrides dds_en)
//   amp_in           : output gain, sampled at the scale stage
//   bus              : ftw handshake, ROM port, sample stream (master side)
module dds_table_reader
    import dds_pkg::*;
#(
    parameter int PHASE_W          = DDS_PHASE_W,
    parameter int SAMPLE_ADDR_BITS = DDS_SAMPLE_ADDR_BITS,
    parameter int DATA_W           = DDS_DATA_W,
    parameter int AMP_W            = DDS_AMP_W
) (
    input  logic                dds_clk,
    input  logic                dds_rst,
    input  logic                dds_en,
    input  logic                phase_clr,
    input  logic [AMP_W-1:0]    amp_in,
    dds_table_reader_if.master  bus
);
    ftw_state_e                  state_q;
    logic [PHASE_W-1:0]          phase_q, phase_d;
    logic [PHASE_W-1:0]          ftw_active_q;
    logic [PHASE_W-1:0]          ftw_shadow_q;
    logic [PHASE_W:0]            sum;
    logic                        carry;
    logic                        advance;
    logic                        ce_q, ce_d;
    logic [SAMPLE_ADDR_BITS-1:0] addr_q, addr_d;
    logic                        ready_q;
    logic [DATA_W-1:0]           raw_q;
    logic                        v1_q;
    logic [DATA_W-1:0]           sample_w;
    logic                        sample_vld_w;

    assign sum     = {1'b0, phase_q} + {1'b0, ftw_active_q};
    assign carry   = sum[PHASE_W];
    assign advance = dds_en & ~phase_clr;

    // Issue stage: clear beats enable; idle cycles hold phase and address.
    always_comb begin
        phase_d = phase_q;
        ce_d    = 1'b0;
        addr_d  = addr_q;
        if (phase_clr) begin
            phase_d = '0;
        end else if (dds_en) begin
            addr_d  = phase_q[PHASE_W-1 -: SAMPLE_ADDR_BITS];
            ce_d    = 1'b1;
            phase_d = sum[PHASE_W-1:0];
        end
    end

    // Issue and capture registers. The ROM updates bram_data on the falling
    // edge inside the ce cycle, so the next rising edge sees the read data.
    always_ff @(posedge dds_clk) begin
        if (dds_rst) begin
            phase_q <= '0;
            ce_q    <= 1'b0;
            addr_q  <= '0;
            raw_q   <= '0;
            v1_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ce_q    <= ce_d;
            addr_q  <= addr_d;
            raw_q   <= bus.bram_data;
            v1_q    <= ce_q;
        end
    end

    // Tuning-word handshake. A held word waits for the wrap so the waveform
    // stays phase-continuous; if the accumulator is not advancing there is
    // no wrap to wait for, so it is applied at once. The wrap-cycle add
    // still uses the old word because sum is built from ftw_active_q.
    always_ff @(posedge dds_clk) begin
        if (dds_rst) begin
            state_q      <= IDLE;
            ftw_shadow_q <= '0;
            ftw_active_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ftw_valid && ready_q) begin
                        ftw_shadow_q <= bus.ftw_in;
                        state_q      <= PENDING;
                        ready_q      <= 1'b0;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                PENDING: begin
                    if (!advance || carry) begin
                        ftw_active_q <= ftw_shadow_q;
                        state_q      <= IDLE;
                        ready_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    dds_amp_scale #(
        .DATA_W (DATA_W),
        .AMP_W  (AMP_W)
    ) u_scale (
        .clk_i    (dds_clk),
        .rst_i    (dds_rst),
        .raw_i    (raw_q),
        .amp_i    (amp_in),
        .vld_i    (v1_q),
        .sample_o (sample_w),
        .vld_o    (sample_vld_w)
    );

    assign bus.ftw_ready    = ready_q;
    assign bus.bram_ce      = ce_q;
    assign bus.bram_addr    = addr_q;
    assign bus.sample_out   = sample_w;
    assign bus.sample_valid = sample_vld_w;
endmodule

// File: tb/tb_dds_table_reader.sv
// Bench for dds_table_reader: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a cycle-level
// behavioural model of the reader and a negedge ROM with entry[k] = k<<8.
module tb_dds_table_reader;
    import dds_pkg::*;

    localparam int PW = 32;
    localparam int AB = 8;
    localparam int DW = 16;
    localparam int AW = 9;

    logic          dds_clk   = 1'b0;
    logic          dds_rst   = 1'b1;
    logic          dds_en    = 1'b0;
    logic          phase_clr = 1'b0;
    logic [AW-1:0] amp_in    = 9'd256;
    logic [DW-1:0] rom_q     = '0;
    logic [DW-1:0] rom [0:255];

    dds_table_reader_if #(.PHASE_W(PW), .SAMPLE_ADDR_BITS(AB), .DATA_W(DW)) bus ();

    dds_table_reader #(
        .PHASE_W(PW), .SAMPLE_ADDR_BITS(AB), .DATA_W(DW), .AMP_W(AW)
    ) dut (
        .dds_clk   (dds_clk),
        .dds_rst   (dds_rst),
        .dds_en    (dds_en),
        .phase_clr (phase_clr),
        .amp_in    (amp_in),
        .bus       (bus.master)
    );

    always #5 dds_clk = ~dds_clk;

    // Wavetable ROM, registered on the falling edge.
    initial for (int k = 0; k < 256; k++) rom[k] = DW'(k << 8);
    always @(negedge dds_clk) if (bus.bram_ce) rom_q <= rom[bus.bram_addr];
    assign bus.bram_data = rom_q;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected scaled sample for table entry addr at gain amp.
    function automatic longint scale(input int addr, input int amp);
        longint e;
        longint a;
        e = longint'(addr) << 8;
        if (e >= 32768) e -= 65536;
        a = (amp > AMP_UNITY) ? AMP_UNITY : amp;
        return ((e * a) >>> 8) & 64'hFFFF;
    endfunction

    // ---------------- behavioural model ----------------
    longint m_phase  = 0;
    longint m_active = 0;
    longint m_shadow = 0;
    bit     m_pend   = 0;
    bit     m_ready  = 0;
    bit     m_ce     = 0;
    int     m_addr   = 0;
    bit     h_ce   [3] = '{0, 0, 0};
    int     h_addr [3] = '{0, 0, 0};
    bit     e_valid = 0;
    longint e_out   = 0;
    bit     e_rst   = 0;

    task automatic model_step();
        bit     adv;
        bit     acc;
        bit     carry;
        longint s;
        if (dds_rst) begin
            m_phase = 0; m_active = 0; m_shadow = 0; m_pend = 0; m_ready = 0;
            m_ce = 0; m_addr = 0;
            for (int i = 0; i < 3; i++) begin h_ce[i] = 0; h_addr[i] = 0; end
            e_valid = 0; e_out = 0; e_rst = 1;
        end else begin
            adv   = dds_en && !phase_clr;
            acc   = !m_pend && m_ready && (bus.ftw_valid === 1'b1);
            carry = 0;
            if (phase_clr) begin
                m_phase = 0;
                m_ce    = 0;
            end else if (dds_en) begin
                m_addr  = int'(m_phase >> 24);
                m_ce    = 1;
                s       = m_phase + m_active;
                carry   = (s >> 32) != 0;
                m_phase = s & 64'hFFFF_FFFF;
            end else begin
                m_ce = 0;
            end
            if (m_pend && (!adv || carry)) begin
                m_active = m_shadow;
                m_pend   = 0;
            end else if (acc) begin
                m_shadow = longint'(bus.ftw_in);
                m_pend   = 1;
            end
            m_ready = !m_pend;
            h_ce[2] = h_ce[1]; h_addr[2] = h_addr[1];
            h_ce[1] = h_ce[0]; h_addr[1] = h_addr[0];
            h_ce[0] = m_ce;    h_addr[0] = m_addr;
            e_valid = h_ce[2];
            if (e_valid) e_out = scale(h_addr[2], int'(amp_in));
            e_rst = 0;
        end
    endtask

    always @(posedge dds_clk) model_step();

    // Per-cycle comparison against the model.
    always @(posedge dds_clk) begin
        #1;
        chk("bram_ce", bus.bram_ce, m_ce);
        chk("bram_addr", bus.bram_addr, m_addr);
        chk("ftw_ready", bus.ftw_ready, m_ready);
        chk("sample_valid", bus.sample_valid, e_valid);
        if (e_valid || e_rst) chk("sample_out", bus.sample_out, e_out);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge dds_clk);
        #1;
    endtask

    // Offer a word with the accumulator stopped: accepted, then applied.
    task automatic set_ftw(input logic [31:0] w);
        int n;
        n = 0;
        while (bus.ftw_ready !== 1'b1 && n < 50) begin tick(); n++; end
        if (bus.ftw_ready !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL ftw_ready_timeout: got 0x%0h expected 0x1", bus.ftw_ready);
        end
        dds_en        = 1'b0;
        bus.ftw_in    = w;
        bus.ftw_valid = 1'b1;
        tick();
        bus.ftw_valid = 1'b0;
        tick();
    endtask

    // Clear, read entry 0 then entry ent, and check the second sample.
    task automatic gain(input int ent, input int amp, input logic [63:0] exp);
        set_ftw(32'(ent) << 24);
        amp_in = AW'(amp);
        phase_clr = 1'b1; dds_en = 1'b0; tick();
        phase_clr = 1'b0; dds_en = 1'b1; tick();
        tick();
        dds_en = 1'b0; tick();
        tick();
        chk("gain_valid", bus.sample_valid, 1);
        chk("gain_out", bus.sample_out, exp);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int     exp_a [6] = '{'h40, 'h80, 'hC0, 'h00, 'h80, 'h00};
    logic   ens   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        bus.ftw_in    = '0;
        bus.ftw_valid = 1'b0;

        // Reset state.
        dds_rst = 1'b1; tick(); tick();
        chk("rst_ce", bus.bram_ce, 0);
        chk("rst_addr", bus.bram_addr, 0);
        chk("rst_out", bus.sample_out, 0);
        chk("rst_valid", bus.sample_valid, 0);
        chk("rst_ready", bus.ftw_ready, 0);
        dds_rst = 1'b0; tick();
        chk("ready_after_rst", bus.ftw_ready, 1);

        // Ramp: addresses 0,1,2,... and samples k<<8 two cycles later.
        set_ftw(32'h0100_0000);
        dds_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ramp_addr", bus.bram_addr, i);
            chk("ramp_ce", bus.bram_ce, 1);
            if (i >= 2) begin
                chk("ramp_valid", bus.sample_valid, 1);
                chk("ramp_out", bus.sample_out, (i - 2) << 8);
            end else begin
                chk("ramp_valid_lat", bus.sample_valid, 0);
            end
        end
        dds_en = 1'b0; tick();

        // Wrap-synchronous update.
        phase_clr = 1'b1; tick(); phase_clr = 1'b0;
        set_ftw(32'h4000_0000);
        dds_en = 1'b1; tick();
        chk("wrap_addr0", bus.bram_addr, 0);
        bus.ftw_in = 32'h8000_0000; bus.ftw_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.ftw_valid = 1'b0;
            chk("wrap_addr", bus.bram_addr, exp_a[i]);
            chk("wrap_ready", bus.ftw_ready, (i < 2) ? 0 : 1);
        end
        dds_en = 1'b0; tick(); tick(); tick();

        // Enable toggling; the held word applies on the first idle edge.
        bus.ftw_in = 32'h0080_0000;
        for (int i = 0; i < 6; i++) begin
            dds_en        = ens[i];
            bus.ftw_valid = (i == 0);
            tick();
            chk("tog_ce", bus.bram_ce, ens[i]);
            if (i >= 2) chk("tog_valid", bus.sample_valid, ens[i-2]);
            if (i < 2)  chk("tog_ready", bus.ftw_ready, i);
        end
        bus.ftw_valid = 1'b0;

        // Gain and clamp.
        gain('h7F, 128, 64'h3F80);
        gain('h7F, 511, 64'h7F00);
        gain('h80, 0,   64'h0000);
        gain('h80, 256, 64'h8000);
        gain('h80, 128, 64'hC000);
        amp_in = 9'd256;

        // phase_clr wins over dds_en.
        set_ftw(32'h0100_0000);
        dds_en = 1'b1; tick(); tick();
        phase_clr = 1'b1; tick();
        chk("clr_ce", bus.bram_ce, 0);
        phase_clr = 1'b0; tick();
        chk("clr_ce_next", bus.bram_ce, 1);
        chk("clr_addr_next", bus.bram_addr, 0);

        // Reset with a pending word and samples in flight.
        bus.ftw_in = 32'h1234_5678; bus.ftw_valid = 1'b1; tick();
        bus.ftw_valid = 1'b0; tick();
        chk("pend_ready", bus.ftw_ready, 0);
        dds_rst = 1'b1; tick();
        chk("mid_rst_ce", bus.bram_ce, 0);
        chk("mid_rst_addr", bus.bram_addr, 0);
        chk("mid_rst_out", bus.sample_out, 0);
        chk("mid_rst_valid", bus.sample_valid, 0);
        chk("mid_rst_ready", bus.ftw_ready, 0);
        dds_rst = 1'b0; tick();
        chk("post_rst_ready", bus.ftw_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dc_addr", bus.bram_addr, 0);
            chk("dc_ce", bus.bram_ce, 1);
        end
        dds_en = 1'b0; tick();

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            dds_rst   = ($urandom_range(0, 299) == 0);
            dds_en    = ($urandom_range(0, 9) < 8);
            phase_clr = ($urandom_range(0, 39) == 0);
            amp_in    = AW'($urandom_range(0, 511));
            bus.ftw_valid = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 2))
                0:       bus.ftw_in = $urandom;
                1:       bus.ftw_in = $urandom_range(0, 32'h03FF_FFFF);
                default: bus.ftw_in = 32'h4000_0000;
            endcase
            tick();
        end
        dds_rst = 1'b0; bus.ftw_valid = 1'b0; dds_en = 1'b0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
